// File: rtl/bcd_7seg_display.sv
// Latches a packed 4-digit BCD value and scans it onto a multiplexed 7-segment display,
// with a dark guard interval at the start of each digit slot, leading-zero blanking and dash decode.
module bcd_7seg_display #(
    parameter int REFRESH_DIV      = 27000,
    parameter int GUARD            = 2,
    parameter int BLANK_LEADING    = 1,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] BCD_code,
    input  logic        valid,
    output logic [3:0]  anodes,
    output logic [6:0]  segments
);

    localparam int             CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
    localparam logic [3:0]     ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
    localparam logic [6:0]     SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [15:0]      disp_val;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;

    logic [3:0] nibble;
    logic [3:0] lead_zero;
    logic       blanked;
    logic       in_guard;
    logic [6:0] seg_on;
    logic [3:0] anode_on;
    logic [3:0] anodes_next;
    logic [6:0] segments_next;

    function automatic logic [6:0] decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    always_comb begin
        nibble = disp_val[3:0];
        case (idx)
            2'd0: nibble = disp_val[3:0];
            2'd1: nibble = disp_val[7:4];
            2'd2: nibble = disp_val[11:8];
            2'd3: nibble = disp_val[15:12];
            default: nibble = disp_val[3:0];
        endcase

        // lead_zero[i]: nibbles 3..i are all zero; the units digit is never blanked
        lead_zero[3] = (disp_val[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (disp_val[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (disp_val[7:4] == 4'd0);
        lead_zero[0] = 1'b0;

        blanked  = (BLANK_LEADING != 0) && lead_zero[idx];
        in_guard = (cnt < GUARD_CNT);
        seg_on   = decode(nibble);
        anode_on = 4'b0001 << idx;

        if (in_guard || blanked) begin
            anodes_next   = ANODE_OFF;
            segments_next = SEG_OFF;
        end else begin
            anodes_next   = (ANODE_ACTIVE_LOW != 0) ? ~anode_on : anode_on;
            segments_next = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_val <= 16'h0000;
            cnt      <= '0;
            idx      <= 2'd0;
            anodes   <= ANODE_OFF;
            segments <= SEG_OFF;
        end else begin
            if (valid) begin
                disp_val <= BCD_code;
            end
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            anodes   <= anodes_next;
            segments <= segments_next;
        end
    end

endmodule

// File: tb/tb_bcd_7seg_display.sv
// Scoreboard bench for bcd_7seg_display with a short refresh slot; a second instance runs with
// leading-zero blanking disabled so both blanking modes are checked from the same stimulus.
module tb_bcd_7seg_display;

    localparam int R = 8;
    localparam int G = 2;

    logic        clk;
    logic        reset;
    logic [15:0] BCD_code;
    logic        valid;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic [3:0]  anodes_nb;
    logic [6:0]  segments_nb;

    bcd_7seg_display #(.REFRESH_DIV(R), .GUARD(G)) dut (
        .clk(clk), .reset(reset), .BCD_code(BCD_code), .valid(valid),
        .anodes(anodes), .segments(segments)
    );

    bcd_7seg_display #(.REFRESH_DIV(R), .GUARD(G), .BLANK_LEADING(0)) dut_nb (
        .clk(clk), .reset(reset), .BCD_code(BCD_code), .valid(valid),
        .anodes(anodes_nb), .segments(segments_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] sg;
        logic [3:0] an_nb;
        logic [6:0] sg_nb;
    } exp_t;

    exp_t        sb_q[$];
    int          checks;
    int          failures;
    int          edge_n;
    logic [15:0] model_val;
    string       scen;

    logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s/%s: got %h expected %h (edge %0d, t=%0t)", scen, tag, obs, exp_v, edge_n, $time);
        end
    endtask

    // Expected outputs after edge k, from the edge-numbering timeline and the value held before edge k
    task automatic model(input logic [15:0] v, input int k, input bit blank_en,
                         output logic [3:0] an, output logic [6:0] sg);
        int pos, d, upper;
        pos   = (k - 1) % R;
        d     = ((k - 1) / R) % 4;
        upper = int'(v) >> (4 * d);
        if (pos < G || (blank_en && d >= 1 && upper == 0)) begin
            an = 4'hF;
            sg = 7'h7F;
        end else begin
            an = ~(4'b0001 << d);
            sg = ~dec_tab[upper & 15];
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d);
        exp_t e, got;
        valid    = v;
        BCD_code = d;
        model(model_val, edge_n + 1, 1'b1, e.an, e.sg);
        model(model_val, edge_n + 1, 1'b0, e.an_nb, e.sg_nb);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        edge_n++;
        if (v) model_val = d;
        got = sb_q.pop_front();
        chk("anodes", {12'h0, anodes}, {12'h0, got.an});
        chk("segments", {9'h0, segments}, {9'h0, got.sg});
        chk("anodes_nb", {12'h0, anodes_nb}, {12'h0, got.an_nb});
        chk("segments_nb", {9'h0, segments_nb}, {9'h0, got.sg_nb});
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) step(1'b0, 16'($urandom));
    endtask

    task automatic outputs_dark(input string tag);
        chk({tag, "_an"}, {12'h0, anodes}, 16'h000F);
        chk({tag, "_sg"}, {9'h0, segments}, 16'h007F);
        chk({tag, "_an_nb"}, {12'h0, anodes_nb}, 16'h000F);
        chk({tag, "_sg_nb"}, {9'h0, segments_nb}, 16'h007F);
    endtask

    // Assert reset between edges (with valid high to show it is ignored), hold 3 cycles, release
    task automatic do_reset();
        reset    = 1'b0;
        valid    = 1'b1;
        BCD_code = 16'h1234;
        #1;
        outputs_dark("rst_immediate");
        repeat (3) @(posedge clk);
        #1;
        outputs_dark("rst_held");
        @(negedge clk);
        valid     = 1'b0;
        reset     = 1'b1;
        edge_n    = 0;
        model_val = 16'h0000;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        edge_n    = 0;
        model_val = 16'h0000;
        reset     = 1'b1;
        valid     = 1'b0;
        BCD_code  = 16'h0000;
        #2;

        scen = "reset";
        do_reset();
        run_to(4 * R + 4);

        scen = "cap_0045";
        do_reset();
        step(1'b1, 16'h0045);
        run_to(13);
        chk("digit1_an", {12'h0, anodes}, 16'h000D);
        chk("digit1_sg", {9'h0, segments}, 16'h0019);
        run_to(4 * R + 8);

        scen = "cap_2047";
        do_reset();
        step(1'b1, 16'h2047);
        run_to(3 * R + 5);
        chk("digit3_an", {12'h0, anodes}, 16'h0007);
        chk("digit3_sg", {9'h0, segments}, 16'h0024);
        run_to(4 * R + 6);

        scen = "cap_00A5";
        do_reset();
        step(1'b1, 16'h00A5);
        run_to(13);
        chk("dash_sg", {9'h0, segments}, 16'h003F);
        run_to(4 * R + 2);

        scen = "mid_reset";
        do_reset();
        step(1'b1, 16'h2047);
        run_to(2 * R + 4);
        chk("digit2_an", {12'h0, anodes}, 16'h000B);
        do_reset();
        run_to(4 * R + 2);

        scen = "valid_hold";
        do_reset();
        step(1'b1, 16'h0001);
        step(1'b1, 16'h0002);
        step(1'b1, 16'h0003);
        run_to(6);
        chk("digit0_sg", {9'h0, segments}, 16'h0030);
        run_to(4 * R);

        scen = "noblank_zero";
        do_reset();
        run_to(3 * R + 5);
        chk("nb_digit3_an", {12'h0, anodes_nb}, 16'h0007);
        chk("nb_digit3_sg", {9'h0, segments_nb}, 16'h0040);
        run_to(4 * R + 1);

        scen = "wrap_capture";
        do_reset();
        run_to(R - 1);
        step(1'b1, 16'h0981);
        run_to(4 * R + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
